prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader: frames of 16-bit words are written into IRAM or DRAM,
// and a run/stop command pair drives the processor start level.
module prog_loader #(
  parameter int TIMEOUT   = 50000,
  parameter int MAX_WORDS = 512
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [8:0]  addr_ext,
  output logic [15:0] Data_in_ins,
  output logic [15:0] Data_in_dram,
  output logic        start_2,
  output logic        iram_write_ext,
  output logic        start_3,
  output logic        dram_write_ext,
  output logic        start,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN_HI  = 3'd1;
  localparam logic [2:0] S_LEN_LO  = 3'd2;
  localparam logic [2:0] S_DATA_HI = 3'd3;
  localparam logic [2:0] S_DATA_LO = 3'd4;
  localparam logic [2:0] S_WRITE   = 3'd5;
  localparam logic [2:0] S_HOLD    = 3'd6;
  localparam logic [2:0] S_RUN     = 3'd7;

  localparam logic [7:0] CMD_IRAM = 8'hA5;
  localparam logic [7:0] CMD_DRAM = 8'h5A;
  localparam logic [7:0] CMD_RUN  = 8'hC3;
  localparam logic [7:0] CMD_STOP = 8'hFF;

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [2:0]    state_q, state_d;
  logic          sel_dram_q, sel_dram_d;
  logic [7:0]    len_hi_q, len_hi_d;
  logic [7:0]    byte_hi_q, byte_hi_d;
  logic [15:0]   word_q, word_d;
  logic [15:0]   rem_q, rem_d;
  logic [8:0]    addr_q, addr_d;
  logic [TW-1:0] idle_q, idle_d;
  logic          start_q, start_d;
  logic          start_2_q, start_2_d;
  logic          iwr_q, iwr_d;
  logic          start_3_q, start_3_d;
  logic          dwr_q, dwr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [15:0]   len_s;
  logic          in_frame_s;

  assign len_s      = {len_hi_q, rx_data};
  assign in_frame_s = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_DATA_HI) || (state_q == S_DATA_LO);

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d    = state_q;
    sel_dram_d = sel_dram_q;
    len_hi_d   = len_hi_q;
    byte_hi_d  = byte_hi_q;
    word_d     = word_q;
    rem_d      = rem_q;
    addr_d     = addr_q;
    idle_d     = {TW{1'b0}};
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (in_frame_s && !rx_valid) begin
      if (idle_q >= TW'(TIMEOUT - 1)) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end else begin
      idle_d = {TW{1'b0}};
    end

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_IRAM: begin state_d = S_LEN_HI; sel_dram_d = 1'b0; end
            CMD_DRAM: begin state_d = S_LEN_HI; sel_dram_d = 1'b1; end
            CMD_RUN:  state_d = S_RUN;
            default:  err_d = 1'b1;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LEN_HI: begin
        if (rx_valid) begin
          len_hi_d = rx_data;
          state_d  = S_LEN_LO;
        end else begin
          len_hi_d = len_hi_q;
        end
      end
      S_LEN_LO: begin
        if (rx_valid) begin
          if (len_s == 16'd0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (len_s > 16'(MAX_WORDS)) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            rem_d   = len_s;
            addr_d  = 9'd0;
            state_d = S_DATA_HI;
          end
        end else begin
          rem_d = rem_q;
        end
      end
      S_DATA_HI: begin
        if (rx_valid) begin
          byte_hi_d = rx_data;
          state_d   = S_DATA_LO;
        end else begin
          byte_hi_d = byte_hi_q;
        end
      end
      S_DATA_LO: begin
        if (rx_valid) begin
          word_d  = {byte_hi_q, rx_data};
          state_d = S_WRITE;
        end else begin
          word_d = word_q;
        end
      end
      // A byte landing while the write strobe/hold is on screen is an overrun
      S_WRITE: begin
        if (rx_valid) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (rx_valid) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (rem_q == 16'd1) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          rem_d   = rem_q - 16'd1;
          addr_d  = addr_q + 9'd1;
          state_d = S_DATA_HI;
        end
      end
      S_RUN: begin
        if (rx_valid && (rx_data == CMD_STOP)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    start_d   = (state_d == S_RUN);
    start_2_d = ((state_d == S_WRITE) || (state_d == S_HOLD)) && !sel_dram_d;
    start_3_d = ((state_d == S_WRITE) || (state_d == S_HOLD)) && sel_dram_d;
    iwr_d     = (state_d == S_WRITE) && !sel_dram_d;
    dwr_d     = (state_d == S_WRITE) && sel_dram_d;
    busy_d    = (state_d != S_IDLE) && (state_d != S_RUN);
  end

  // State, datapath and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      sel_dram_q <= 1'b0;
      len_hi_q   <= 8'd0;
      byte_hi_q  <= 8'd0;
      word_q     <= 16'd0;
      rem_q      <= 16'd0;
      addr_q     <= 9'd0;
      idle_q     <= {TW{1'b0}};
      start_q    <= 1'b0;
      start_2_q  <= 1'b0;
      iwr_q      <= 1'b0;
      start_3_q  <= 1'b0;
      dwr_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_dram_q <= sel_dram_d;
      len_hi_q   <= len_hi_d;
      byte_hi_q  <= byte_hi_d;
      word_q     <= word_d;
      rem_q      <= rem_d;
      addr_q     <= addr_d;
      idle_q     <= idle_d;
      start_q    <= start_d;
      start_2_q  <= start_2_d;
      iwr_q      <= iwr_d;
      start_3_q  <= start_3_d;
      dwr_q      <= dwr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign addr_ext       = addr_q;
  assign Data_in_ins    = word_q;
  assign Data_in_dram   = word_q;
  assign start          = start_q;
  assign start_2        = start_2_q;
  assign iram_write_ext = iwr_q;
  assign start_3        = start_3_q;
  assign dram_write_ext = dwr_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule
